// File: rtl/reset_sequencer_pkg.sv
// Shared types and helpers for the staggered reset sequencer.
package reset_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_HOLD    = 2'd0,
        ST_RELEASE = 2'd1,
        ST_RUN     = 2'd2
    } state_t;

    localparam int MAX_CH = 32;

    // Index of the lowest set bit; 0 when the vector is empty.
    function automatic int lowest_set(input logic [MAX_CH-1:0] vec);
        int idx;
        idx = 0;
        for (int i = MAX_CH - 1; i >= 0; i--) begin
            if (vec[i]) idx = i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/reset_sequencer_timer.sv
// Clear/enable up-counter that saturates at a terminal count supplied by the caller.
module reset_sequencer_timer #(
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             i_clr,
    input  logic             i_en,
    input  logic [CNT_W-1:0] i_tc,
    output logic             o_done
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (i_clr) begin
            r_count <= '0;
        end else if (i_en && (r_count < i_tc)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_done = (r_count >= i_tc);

endmodule

// File: rtl/reset_sequencer.sv
// Releases NUM_CH active-low block resets in index order after a hold time, with
// per-channel software reset that cascades upward and re-releases in order.
//
//  state   | meaning
//  HOLD    | channel start_idx (and above) held low, waiting MIN_ASSERT quiet cycles
//  RELEASE | staggering release of channels next_idx .. NUM_CH-1
//  RUN     | all channels released
module reset_sequencer
    import reset_sequencer_pkg::*;
#(
    parameter int NUM_CH         = 4,
    parameter int MIN_ASSERT     = 8,
    parameter int STAGGER_CYCLES = 16
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              scan_bypass,
    input  logic [NUM_CH-1:0] sw_rst_req,
    output logic [NUM_CH-1:0] rst_n_out,
    output logic              seq_done,
    output logic              busy
);

    localparam int CNT_W = $clog2(((MIN_ASSERT > STAGGER_CYCLES) ? MIN_ASSERT : STAGGER_CYCLES) + 1);
    localparam int IDX_W = $clog2(NUM_CH + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [IDX_W-1:0]  r_start_idx;
    logic [IDX_W-1:0]  r_next_idx;
    logic [IDX_W-1:0]  w_start_nxt;
    logic [IDX_W-1:0]  w_next_nxt;
    logic [IDX_W-1:0]  w_req_idx;
    logic [IDX_W-1:0]  w_rel_idx;
    logic [NUM_CH-1:0] r_rst_n;
    logic [NUM_CH-1:0] w_rst_n_nxt;
    logic              r_seq_done;
    logic              r_busy;
    logic              w_seq_done_nxt;
    logic              w_busy_nxt;
    logic              w_req_any;
    logic              w_cascade;
    logic              w_hold_block;
    logic              w_fire;
    logic              w_timer_clr;
    logic              w_timer_done;
    logic [CNT_W-1:0]  w_tc;

    assign w_req_any = |sw_rst_req;
    assign w_req_idx = IDX_W'(lowest_set(MAX_CH'(sw_rst_req)));

    // The release edge itself is the first stagger cycle, hence the -1 in RELEASE.
    assign w_tc        = (r_state == ST_HOLD) ? CNT_W'(MIN_ASSERT) : CNT_W'(STAGGER_CYCLES - 1);
    assign w_timer_clr = !resetn || w_cascade || w_fire || w_hold_block;

    reset_sequencer_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk    (clk),
        .i_clr  (w_timer_clr),
        .i_en   (r_state != ST_RUN),
        .i_tc   (w_tc),
        .o_done (w_timer_done)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state     <= ST_HOLD;
            r_start_idx <= '0;
            r_next_idx  <= '0;
            r_rst_n     <= '0;
            r_seq_done  <= 1'b0;
            r_busy      <= 1'b1;
        end else begin
            r_state     <= w_state_nxt;
            r_start_idx <= w_start_nxt;
            r_next_idx  <= w_next_nxt;
            r_rst_n     <= w_rst_n_nxt;
            r_seq_done  <= w_seq_done_nxt;
            r_busy      <= w_busy_nxt;
        end
    end

    always_comb begin
        w_cascade    = 1'b0;
        w_hold_block = 1'b0;
        w_state_nxt  = r_state;
        // A request only matters if its channel is already out of reset.
        if (w_req_any) begin
            case (r_state)
                ST_RUN:     w_cascade = 1'b1;
                ST_HOLD: begin
                    if (w_req_idx < r_start_idx)       w_cascade    = 1'b1;
                    else if (w_req_idx == r_start_idx) w_hold_block = 1'b1;
                end
                ST_RELEASE: w_cascade = (w_req_idx < r_next_idx);
                default:    w_cascade = 1'b0;
            endcase
        end
        w_fire = (r_state != ST_RUN) && w_timer_done && !w_cascade && !w_hold_block;
        if (w_cascade) begin
            w_state_nxt = ST_HOLD;
        end else if (w_fire) begin
            case (r_state)
                ST_HOLD:    w_state_nxt = (r_start_idx == LAST_IDX) ? ST_RUN : ST_RELEASE;
                ST_RELEASE: w_state_nxt = (r_next_idx == LAST_IDX) ? ST_RUN : ST_RELEASE;
                default:    w_state_nxt = ST_HOLD;
            endcase
        end else if ((r_state != ST_HOLD) && (r_state != ST_RELEASE) && (r_state != ST_RUN)) begin
            w_state_nxt = ST_HOLD;
        end
    end

    always_comb begin
        w_rst_n_nxt = r_rst_n;
        w_start_nxt = r_start_idx;
        w_next_nxt  = r_next_idx;
        w_rel_idx   = (r_state == ST_HOLD) ? r_start_idx : r_next_idx;
        for (int i = 0; i < NUM_CH; i++) begin
            if (w_cascade && (IDX_W'(i) >= w_req_idx)) w_rst_n_nxt[i] = 1'b0;
            if (w_fire && (IDX_W'(i) == w_rel_idx))    w_rst_n_nxt[i] = 1'b1;
        end
        if (w_cascade) begin
            w_start_nxt = w_req_idx;
            w_next_nxt  = w_req_idx;
        end else if (w_fire) begin
            w_next_nxt = w_rel_idx + 1'b1;
        end
        w_seq_done_nxt = (r_state == ST_RUN) && (w_state_nxt == ST_RUN);
        w_busy_nxt     = !w_seq_done_nxt;
    end

    assign rst_n_out = scan_bypass ? {NUM_CH{resetn}} : r_rst_n;
    assign seq_done  = scan_bypass ? resetn : r_seq_done;
    assign busy      = r_busy;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: timeline sequences, a scan-bypass vector table and
// randomized traffic against a release-time model.
module tb_reset_sequencer;

    localparam int N    = 4;
    localparam int MIN  = 8;
    localparam int STAG = 16;

    logic         clk = 1'b0;
    logic         resetn = 1'b0;
    logic         scan_bypass = 1'b0;
    logic [N-1:0] sw_rst_req = '0;
    logic [N-1:0] rst_n_out;
    logic         seq_done;
    logic         busy;

    always #5 clk = ~clk;

    reset_sequencer #(
        .NUM_CH         (N),
        .MIN_ASSERT     (MIN),
        .STAGGER_CYCLES (STAG)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .scan_bypass (scan_bypass),
        .sw_rst_req  (sw_rst_req),
        .rst_n_out   (rst_n_out),
        .seq_done    (seq_done),
        .busy        (busy)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Model: b = lowest channel not guaranteed released, t = quiet edges since the
    // last reset cause. Channel k>=b is out of reset once t >= MIN+1+(k-b)*STAG.
    int           m_b = 0;
    int           m_t = 0;
    logic [N-1:0] m_out = '0;
    logic         m_done = 1'b0;

    task automatic model_edge(input logic rn, input logic [N-1:0] req);
        int j;
        j = 0;
        for (int i = N - 1; i >= 0; i--) if (req[i]) j = i;
        if (!rn) begin
            m_b = 0;
            m_t = 0;
        end else if (req != '0) begin
            if (m_out[j]) begin
                m_b = j;
                m_t = 0;
            end else if (j == m_b) begin
                m_t = 0;
            end else if (m_t < 100000) begin
                m_t++;
            end
        end else if (m_t < 100000) begin
            m_t++;
        end
        for (int k = 0; k < N; k++)
            m_out[k] = (k < m_b) ? 1'b1 : (m_t >= MIN + 1 + (k - m_b) * STAG);
        m_done = (m_t >= MIN + 2 + (N - 1 - m_b) * STAG);
    endtask

    task automatic edge_and_compare();
        logic [N-1:0] exp_out;
        logic         exp_done;
        @(posedge clk);
        model_edge(resetn, sw_rst_req);
        #1;
        exp_out  = scan_bypass ? {N{resetn}} : m_out;
        exp_done = scan_bypass ? resetn : m_done;
        check("model_rst_n_out", 32'(rst_n_out), 32'(exp_out));
        check("model_seq_done", 32'(seq_done), 32'(exp_done));
        check("model_busy", 32'(busy), 32'(!m_done));
    endtask

    task automatic step(input logic rn, input logic sb, input logic [N-1:0] req);
        @(negedge clk);
        resetn      = rn;
        scan_bypass = sb;
        sw_rst_req  = req;
        edge_and_compare();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, '0);
    endtask

    // Call right after the first edge with resetn high.
    task automatic timeline_from_e0(input string tag);
        check({tag, "_out_e0"}, 32'(rst_n_out), 32'b0000);
        idle(7);  check({tag, "_out_e7"},   32'(rst_n_out), 32'b0000);
        idle(1);  check({tag, "_out_e8"},   32'(rst_n_out), 32'b0001);
        idle(15); check({tag, "_out_e23"},  32'(rst_n_out), 32'b0001);
        idle(1);  check({tag, "_out_e24"},  32'(rst_n_out), 32'b0011);
        idle(15); check({tag, "_out_e39"},  32'(rst_n_out), 32'b0011);
        idle(1);  check({tag, "_out_e40"},  32'(rst_n_out), 32'b0111);
        idle(15); check({tag, "_out_e55"},  32'(rst_n_out), 32'b0111);
        idle(1);  check({tag, "_out_e56"},  32'(rst_n_out), 32'b1111);
                  check({tag, "_done_e56"}, 32'(seq_done),  32'b0);
        idle(1);  check({tag, "_done_e57"}, 32'(seq_done),  32'b1);
                  check({tag, "_busy_e57"}, 32'(busy),      32'b0);
    endtask

    typedef struct {
        logic         rn;
        logic         sb;
        logic [N-1:0] req;
        logic [N-1:0] exp_out;
        logic         exp_done;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int           rst_hold;
        int           req_hold;
        logic [N-1:0] cur_req;

        // Power-on reset then full release timeline.
        repeat (5) step(1'b0, 1'b0, '0);
        check("reset_out", 32'(rst_n_out), 32'b0000);
        check("reset_done", 32'(seq_done), 32'b0);
        check("reset_busy", 32'(busy), 32'b1);
        step(1'b1, 1'b0, '0);
        timeline_from_e0("t1");

        // One-cycle request on channel 2 while running.
        step(1'b1, 1'b0, 4'b0100);
        check("t2_out_T", 32'(rst_n_out), 32'b0011);
        check("t2_busy_T", 32'(busy), 32'b1);
        idle(8);  check("t2_out_T8",   32'(rst_n_out), 32'b0011);
        idle(1);  check("t2_out_T9",   32'(rst_n_out), 32'b0111);
        idle(15); check("t2_out_T24",  32'(rst_n_out), 32'b0111);
        idle(1);  check("t2_out_T25",  32'(rst_n_out), 32'b1111);
                  check("t2_done_T25", 32'(seq_done),  32'b0);
        idle(1);  check("t2_done_T26", 32'(seq_done),  32'b1);

        // Long request on channel 1: hold measured from deassertion.
        repeat (20) step(1'b1, 1'b0, 4'b0010);
        check("t3_out_held", 32'(rst_n_out), 32'b0001);
        step(1'b1, 1'b0, '0);
        idle(7);  check("t3_out_T7",  32'(rst_n_out), 32'b0001);
        idle(1);  check("t3_out_T8",  32'(rst_n_out), 32'b0011);
        idle(16); check("t3_out_T24", 32'(rst_n_out), 32'b0111);
        idle(16); check("t3_out_T40", 32'(rst_n_out), 32'b1111);
        idle(1);  check("t3_done_T41", 32'(seq_done), 32'b1);

        // Simultaneous requests: lowest index wins.
        step(1'b1, 1'b0, 4'b1010);
        check("t4_out_T", 32'(rst_n_out), 32'b0001);
        idle(8);  check("t4_out_T8",  32'(rst_n_out), 32'b0001);
        idle(1);  check("t4_out_T9",  32'(rst_n_out), 32'b0011);
        idle(16); check("t4_out_T25", 32'(rst_n_out), 32'b0111);
        idle(16); check("t4_out_T41", 32'(rst_n_out), 32'b1111);
        idle(1);  check("t4_done_T42", 32'(seq_done), 32'b1);

        // resetn dropped mid-RELEASE restarts the whole sequence.
        repeat (3) step(1'b0, 1'b0, '0);
        step(1'b1, 1'b0, '0);
        idle(30); check("t5_out_e30", 32'(rst_n_out), 32'b0011);
        step(1'b0, 1'b0, '0);
        check("t5_out_reset", 32'(rst_n_out), 32'b0000);
        check("t5_busy_reset", 32'(busy), 32'b1);
        step(1'b1, 1'b0, '0);
        timeline_from_e0("t5");

        // Scan bypass: outputs follow resetn combinationally.
        vecs[0] = '{1'b0, 1'b1, 4'b0000, 4'b0000, 1'b0};
        vecs[1] = '{1'b1, 1'b1, 4'b0000, 4'b1111, 1'b1};
        vecs[2] = '{1'b0, 1'b1, 4'b0100, 4'b0000, 1'b0};
        vecs[3] = '{1'b1, 1'b1, 4'b0000, 4'b1111, 1'b1};
        vecs[4] = '{1'b0, 1'b1, 4'b0000, 4'b0000, 1'b0};
        vecs[5] = '{1'b1, 1'b1, 4'b0000, 4'b1111, 1'b1};
        for (int v = 0; v < 6; v++) begin
            @(negedge clk);
            resetn      = vecs[v].rn;
            scan_bypass = vecs[v].sb;
            sw_rst_req  = vecs[v].req;
            #1;
            check($sformatf("t6_vec%0d_out", v), 32'(rst_n_out), 32'(vecs[v].exp_out));
            check($sformatf("t6_vec%0d_done", v), 32'(seq_done), 32'(vecs[v].exp_done));
            edge_and_compare();
        end
        step(1'b1, 1'b0, '0);
        check("t6_out_registered", 32'(rst_n_out), 32'b0000);
        check("t6_done_registered", 32'(seq_done), 32'b0);

        // Randomized traffic against the model.
        rst_hold = 0;
        req_hold = 0;
        cur_req  = '0;
        for (int c = 0; c < 3000; c++) begin
            if (rst_hold > 0) rst_hold--;
            else if ($urandom_range(0, 199) == 0) rst_hold = $urandom_range(1, 4);
            if (req_hold > 0) begin
                req_hold--;
            end else begin
                cur_req = '0;
                if ($urandom_range(0, 29) == 0) begin
                    cur_req  = 4'($urandom_range(1, 15));
                    req_hold = $urandom_range(0, 20);
                end
            end
            step(rst_hold == 0, $urandom_range(0, 99) < 3, cur_req);
        end
        idle(70);
        check("final_done", 32'(seq_done), 32'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
